// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter that lets NREQ byte producers share a single
//            uart_tx. Each granted byte is launched with a one-cycle start
//            pulse and tracked until uart_tx reports completion. A watchdog
//            aborts the byte if completion never arrives.
// Ports    : clk          - single clock, rising edge
//            reset        - synchronous, active-high
//            req[NREQ]    - level requests, held until the matching ack
//            data[NREQ*8] - packed bytes, requester i at [8i+7:8i]
//            ack[NREQ]    - one-cycle pulse: requester's byte latched
//            done[NREQ]   - one-cycle pulse: requester's byte fully sent
//            err          - one-cycle pulse: watchdog abort
//            tx_start     - one-cycle start pulse to uart_tx
//            tx_din[8]    - byte presented to uart_tx
//            tx_done_tick - completion pulse from uart_tx
//            busy         - high whenever the FSM is not idle
//            grant_id[IW] - current or most recent owner
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2,
    parameter int TO_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic              tx_start,
    output logic [7:0]        tx_din,
    input  logic              tx_done_tick,
    output logic              busy,
    output logic [IW-1:0]     grant_id
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_last_grant;
    logic [TO_W-1:0] r_wdog;

    logic            w_found;
    logic [IW-1:0]   w_winner;
    logic [IW:0]     w_idx;
    logic [7:0]      w_win_byte;
    logic [TO_W-1:0] w_wdog_inc;

    // Round-robin search: start one past the last owner and walk upward with
    // wrap-around; the first asserted request wins. The extra index bit keeps
    // last_grant + k from overflowing before the modulo subtraction.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = {1'b0, r_last_grant} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(NREQ)) begin
                w_idx = w_idx - (IW+1)'(NREQ);
            end
            if (!w_found && req[w_idx[IW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[IW-1:0];
            end
        end
    end

    assign w_win_byte = data[{w_winner, 3'b000} +: 8];
    assign w_wdog_inc = r_wdog + TO_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= IW'(NREQ - 1);
            r_wdog       <= '0;
            ack          <= '0;
            done         <= '0;
            err          <= 1'b0;
            tx_start     <= 1'b0;
            tx_din       <= 8'h00;
            busy         <= 1'b0;
            grant_id     <= '0;
        end else begin
            // All pulse outputs default low so each lasts exactly one cycle.
            ack      <= '0;
            done     <= '0;
            err      <= 1'b0;
            tx_start <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // Requests are committed only here; the pulses below are
                    // registered so they are visible during the LAUNCH cycle.
                    if (w_found) begin
                        r_state        <= S_LAUNCH;
                        tx_din         <= w_win_byte;
                        grant_id       <= w_winner;
                        r_last_grant   <= w_winner;
                        ack[w_winner]  <= 1'b1;
                        tx_start       <= 1'b1;
                        busy           <= 1'b1;
                    end
                end

                S_LAUNCH: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    // Completion is checked first so a tick coinciding with
                    // the watchdog expiry still reports done and not err.
                    // The watchdog expires on the edge where the counter would
                    // become all-ones, i.e. 2**TO_W-1 cycles after entering.
                    if (tx_done_tick) begin
                        done[grant_id] <= 1'b1;
                        r_state        <= S_IDLE;
                        busy           <= 1'b0;
                    end else if (&w_wdog_inc) begin
                        err     <= 1'b1;
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_wdog <= w_wdog_inc;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter (NREQ=4, TO_W=4).
//            Cycle vectors from a table plus hand sequences for the watchdog
//            and mid-transfer reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int IW   = 2;
    localparam int TO_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] data;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   done;
    logic              err;
    logic              tx_start;
    logic [7:0]        tx_din;
    logic              tx_done_tick;
    logic              busy;
    logic [IW-1:0]     grant_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ (NREQ),
        .IW   (IW),
        .TO_W (TO_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .data         (data),
        .ack          (ack),
        .done         (done),
        .err          (err),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    typedef struct packed {
        logic [3:0] ack;
        logic [3:0] done;
        logic       err;
        logic       start;
        logic [7:0] din;
        logic       busy;
        logic [1:0] gid;
    } outs_t;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic       tick;
        outs_t      exp;
    } vec_t;

    outs_t act;
    assign act = {ack, done, err, tx_start, tx_din, busy, grant_id};

    int total = 0;
    int bad   = 0;

    localparam int NVEC = 33;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic t,
                                input logic [3:0] a, input logic [3:0] d, input logic e,
                                input logic s, input logic [7:0] x, input logic b,
                                input logic [1:0] g);
        vec_t v;
        v = {r, q, t, a, d, e, s, x, b, g};
        return v;
    endfunction

    // Apply inputs on the falling edge, then sample just after the rising edge.
    task automatic step(input logic r, input logic [3:0] q, input logic t);
        @(negedge clk);
        reset        = r;
        req          = q;
        tx_done_tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input outs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got ack=%b done=%b err=%b start=%b din=%h busy=%b gid=%0d ; want ack=%b done=%b err=%b start=%b din=%h busy=%b gid=%0d",
                     name, act.ack, act.done, act.err, act.start, act.din, act.busy, act.gid,
                     exp.ack, exp.done, exp.err, exp.start, exp.din, exp.busy, exp.gid);
        end
    endtask

    task automatic check_sig(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        // d3=44 d2=A5 d1=22 d0=11
        data         = 32'h44A5_2211;
        reset        = 1'b1;
        req          = '0;
        tx_done_tick = 1'b0;

        //              rst req      tick  ack      done     err  st   din    busy gid
        tbl[0]  = mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00, 0, 2'd0); // reset
        tbl[1]  = mk(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 8'h00, 0, 2'd0); // spurious tick idle
        tbl[2]  = mk(0, 4'b0100, 0, 4'b0100, 4'b0000, 0, 1, 8'hA5, 1, 2'd2); // single request
        tbl[3]  = mk(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 8'hA5, 1, 2'd2); // tick in LAUNCH ignored
        tbl[4]  = mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'hA5, 1, 2'd2);
        tbl[5]  = mk(0, 4'b0000, 1, 4'b0000, 4'b0100, 0, 0, 8'hA5, 0, 2'd2); // done[2]
        tbl[6]  = mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'hA5, 0, 2'd2);
        tbl[7]  = mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00, 0, 2'd0); // reset again
        tbl[8]  = mk(0, 4'b1111, 0, 4'b0001, 4'b0000, 0, 1, 8'h11, 1, 2'd0); // rr: 0
        tbl[9]  = mk(0, 4'b1110, 0, 4'b0000, 4'b0000, 0, 0, 8'h11, 1, 2'd0);
        tbl[10] = mk(0, 4'b1110, 1, 4'b0000, 4'b0001, 0, 0, 8'h11, 0, 2'd0);
        tbl[11] = mk(0, 4'b1111, 0, 4'b0010, 4'b0000, 0, 1, 8'h22, 1, 2'd1); // rr: 1
        tbl[12] = mk(0, 4'b1101, 0, 4'b0000, 4'b0000, 0, 0, 8'h22, 1, 2'd1);
        tbl[13] = mk(0, 4'b1101, 1, 4'b0000, 4'b0010, 0, 0, 8'h22, 0, 2'd1);
        tbl[14] = mk(0, 4'b1111, 0, 4'b0100, 4'b0000, 0, 1, 8'hA5, 1, 2'd2); // rr: 2
        tbl[15] = mk(0, 4'b1011, 0, 4'b0000, 4'b0000, 0, 0, 8'hA5, 1, 2'd2);
        tbl[16] = mk(0, 4'b1011, 1, 4'b0000, 4'b0100, 0, 0, 8'hA5, 0, 2'd2);
        tbl[17] = mk(0, 4'b1111, 0, 4'b1000, 4'b0000, 0, 1, 8'h44, 1, 2'd3); // rr: 3
        tbl[18] = mk(0, 4'b0111, 0, 4'b0000, 4'b0000, 0, 0, 8'h44, 1, 2'd3);
        tbl[19] = mk(0, 4'b0111, 1, 4'b0000, 4'b1000, 0, 0, 8'h44, 0, 2'd3);
        tbl[20] = mk(0, 4'b1111, 0, 4'b0001, 4'b0000, 0, 1, 8'h11, 1, 2'd0); // rr: 0 again
        tbl[21] = mk(0, 4'b1000, 0, 4'b0000, 4'b0000, 0, 0, 8'h11, 1, 2'd0);
        tbl[22] = mk(0, 4'b1000, 1, 4'b0000, 4'b0001, 0, 0, 8'h11, 0, 2'd0);
        tbl[23] = mk(0, 4'b1000, 0, 4'b1000, 4'b0000, 0, 1, 8'h44, 1, 2'd3); // last=3
        tbl[24] = mk(0, 4'b1001, 0, 4'b0000, 4'b0000, 0, 0, 8'h44, 1, 2'd3); // req change ignored
        tbl[25] = mk(0, 4'b1001, 1, 4'b0000, 4'b1000, 0, 0, 8'h44, 0, 2'd3);
        tbl[26] = mk(0, 4'b1001, 0, 4'b0001, 4'b0000, 0, 1, 8'h11, 1, 2'd0); // wrap -> 0
        tbl[27] = mk(0, 4'b1001, 0, 4'b0000, 4'b0000, 0, 0, 8'h11, 1, 2'd0);
        tbl[28] = mk(0, 4'b1001, 1, 4'b0000, 4'b0001, 0, 0, 8'h11, 0, 2'd0);
        tbl[29] = mk(0, 4'b1001, 0, 4'b1000, 4'b0000, 0, 1, 8'h44, 1, 2'd3); // then 3, 1-cycle gap
        tbl[30] = mk(0, 4'b0100, 0, 4'b0000, 4'b0000, 0, 0, 8'h44, 1, 2'd3); // req in LAUNCH ignored
        tbl[31] = mk(0, 4'b0100, 1, 4'b0000, 4'b1000, 0, 0, 8'h44, 0, 2'd3); // req in WAIT ignored
        tbl[32] = mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h44, 0, 2'd3); // dropped: no grant

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].tick);
            check_all($sformatf("vec%0d", i), tbl[i].exp);
        end

        // ---- Watchdog timeout: err 15 cycles after entering WAIT ----
        step(1, 4'b0000, 0);
        step(0, 4'b0001, 0);
        check_all("wd_launch", {4'b0001, 4'b0000, 1'b0, 1'b1, 8'h11, 1'b1, 2'd0});
        step(0, 4'b0000, 0);                       // now in WAIT
        for (int k = 1; k <= 14; k++) begin
            step(0, 4'b0000, 0);
            check_sig($sformatf("wd_wait%0d", k), {5'b0, err, busy, |done}, 8'h02);
        end
        step(0, 4'b0000, 0);
        check_all("wd_err", {4'b0000, 4'b0000, 1'b1, 1'b0, 8'h11, 1'b0, 2'd0});
        // Aborted requester 0 loses its turn: 1 wins over 0.
        step(0, 4'b0011, 0);
        check_all("wd_after", {4'b0010, 4'b0000, 1'b0, 1'b1, 8'h22, 1'b1, 2'd1});

        // ---- tick coinciding with watchdog expiry: done wins ----
        step(0, 4'b0000, 0);
        for (int k = 1; k <= 14; k++) begin
            step(0, 4'b0000, 0);
        end
        check_sig("race_pre", {5'b0, err, busy, |done}, 8'h02);
        step(0, 4'b0000, 1);
        check_all("race_done", {4'b0000, 4'b0010, 1'b0, 1'b0, 8'h22, 1'b0, 2'd1});
        step(0, 4'b0000, 0);
        check_sig("race_after", {6'b0, err, |done}, 8'h00);

        // ---- reset mid-WAIT ----
        step(0, 4'b0100, 0);
        check_all("rst_launch", {4'b0100, 4'b0000, 1'b0, 1'b1, 8'hA5, 1'b1, 2'd2});
        step(0, 4'b0000, 0);
        step(0, 4'b0000, 0);
        check_sig("rst_busy", {7'b0, busy}, 8'h01);
        step(1, 4'b0000, 0);
        check_all("rst_vals", {4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0});
        for (int k = 0; k < 3; k++) begin
            step(0, 4'b0000, 1);
            check_all($sformatf("rst_quiet%0d", k), {4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0});
        end
        step(0, 4'b1111, 0);
        check_all("rst_rr0", {4'b0001, 4'b0000, 1'b0, 1'b1, 8'h11, 1'b1, 2'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing one uart_tx (2..8).
REQ-002 The block SHALL have parameter IW, default 2, giving the width of the grant index, equal to ceil(log2(NREQ)).
REQ-003 The block SHALL have parameter TO_W, default 20, giving the watchdog counter width.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  NREQ  per-requester level request; held high until the matching ack pulse.
REQ-007 data  in  NREQ*8  packed bytes; requester i occupies bits [8i+7:8i].
REQ-008 ack  out  NREQ  one-cycle pulse: byte of requester i accepted and latched.
REQ-009 done  out  NREQ  one-cycle pulse: requester i's byte fully transmitted, stop bit included.
REQ-010 err  out  1  one-cycle pulse: watchdog abort of the current byte.
REQ-011 tx_start  out  1  one-cycle start pulse to uart_tx.
REQ-012 tx_din  out  8  byte presented to uart_tx.
REQ-013 tx_done_tick  in  1  completion pulse from uart_tx.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 grant_id  out  IW  index of the current or most recent owner.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, LAUNCH and WAIT.
REQ-017 All outputs SHALL be registered.
REQ-018 IDLE: req SHALL be sampled only in IDLE; if any bit is set, the arbiter selects winner w, latches data[w] into tx_din, sets grant_id=w and moves to LAUNCH.
REQ-019 IDLE with req=0: the FSM SHALL stay in IDLE.
REQ-020 Winner selection SHALL be round-robin: search starts at (last_grant+1) mod NREQ and proceeds upward with wrap-around; the first set bit wins.
REQ-021 last_grant SHALL update to w when the FSM enters LAUNCH.
REQ-022 LAUNCH: the block SHALL assert tx_start=1 and ack[w]=1 for exactly one cycle, clear the watchdog, then go to WAIT.
REQ-023 Latency SHALL be 1 cycle: req seen in IDLE at cycle N gives ack and tx_start at cycle N+1.
REQ-024 WAIT: on tx_done_tick=1, the block SHALL pulse done[grant_id] next cycle and return to IDLE.
REQ-025 The next arbitration SHALL happen in that IDLE cycle, so the minimum gap between the done pulse and the next tx_start is 1 cycle.
REQ-026 tx_din SHALL stay stable from LAUNCH until the next IDLE-to-LAUNCH transition.
REQ-027 Watchdog: a TO_W-bit counter SHALL increment every cycle in WAIT.
REQ-028 When the counter reaches all-ones without tx_done_tick, the block SHALL pulse err for 1 cycle, suppress done and return to IDLE.
REQ-029 last_grant SHALL keep its value after a watchdog abort, so the aborted requester loses its turn.
REQ-030 If tx_done_tick arrives in the same cycle the counter reaches all-ones, done SHALL win and err SHALL NOT pulse.
REQ-031 tx_done_tick in IDLE or LAUNCH SHALL be ignored.
REQ-032 req changes outside IDLE SHALL be ignored.
REQ-033 A req bit still high in the IDLE cycle after the owner's done pulse SHALL count as a new request; each requester drops req after ack unless it has another byte.
REQ-034 A requester dropping req before ack SHALL NOT be granted, because the grant is committed only from IDLE sampling.
REQ-035 At most one bit of ack, and at most one bit of done, SHALL be high in any cycle.

Reset
REQ-036 reset=1 at a clock edge SHALL force state IDLE from any state, including mid-WAIT.
REQ-037 Reset SHALL set ack=0, done=0, err=0, tx_start=0, busy=0, tx_din=8'h00 and grant_id=0.
REQ-038 Reset SHALL set the watchdog to 0 and last_grant=NREQ-1, so requester 0 has highest priority first.
REQ-039 No done or err pulse SHALL be generated for a byte aborted by reset.
REQ-040 uart_tx shares the same reset.

Verification
REQ-041 Single request: req=4'b0100, data[23:16]=8'hA5 -> next cycle tx_start=1, ack=4'b0100, tx_din=8'hA5, grant_id=2; after tx_done_tick, done=4'b0100 for one cycle, busy=0.
REQ-042 Round-robin: req=4'b1111 held, each source dropping req after its own ack and reasserting it after its done -> grant order 0,1,2,3,0; no starvation.
REQ-043 Wrap-around: last_grant=3, req=4'b1001 -> grant 0; then req=4'b1001 again -> grant 3.
REQ-044 Watchdog: TO_W=4, no tx_done_tick -> err pulses 15 cycles after entering WAIT, done stays 0, FSM returns to IDLE; also cover tx_done_tick on cycle 15 -> done pulses, err=0.
REQ-045 Reset mid-WAIT: assert reset 3 cycles after tx_start -> next cycle busy=0 and all outputs at reset values; no done or err pulse; the next request arbitrates from requester 0.
REQ-046 Spurious tick: tx_done_tick=1 in IDLE with req=0 -> no done pulse, state stays IDLE.
